// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter FSM encoding.
// Imported by the ALU, the arbiter and its interface.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle for the shared ALU.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [WIDTH-1:0] req_a_0;
  logic [WIDTH-1:0] req_a_1;
  logic [WIDTH-1:0] req_b_0;
  logic [WIDTH-1:0] req_b_1;
  logic [2:0]       req_op_0;
  logic [2:0]       req_op_1;
  logic             rsp_valid_0;
  logic             rsp_valid_1;
  logic             rsp_ready_0;
  logic             rsp_ready_1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             busy;

  modport master (
    output req_valid_0, req_valid_1,
    output req_a_0, req_a_1,
    output req_b_0, req_b_1,
    output req_op_0, req_op_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1,
    input  rsp_result, rsp_zero, busy
  );

  modport slave (
    input  req_valid_0, req_valid_1,
    input  req_a_0, req_a_1,
    input  req_b_0, req_b_1,
    input  req_op_0, req_op_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1,
    output rsp_result, rsp_zero, busy
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU; unused opcodes yield 0.
// Zero flag reflects the produced result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}},
                           $signed(i_a) < $signed(i_b)};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two execute-stage requesters.
// One transaction in flight: IDLE accepts, EXEC computes, RESP returns.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  state_t           r_state;
  logic             r_prio;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_rv0;
  logic             r_rv1;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_rsp_rdy;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;

  // r_prio names the port that wins a tie
  assign w_idle = (r_state == ST_IDLE) & ~reset;
  assign w_gnt0 = w_idle & bus.req_valid_0
                & (~bus.req_valid_1 | ~r_prio);
  assign w_gnt1 = w_idle & bus.req_valid_1
                & (~bus.req_valid_0 | r_prio);

  assign w_rsp_rdy = r_owner ? bus.rsp_ready_1
                             : bus.rsp_ready_0;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_owner <= w_gnt1;
            r_a     <= w_gnt1 ? bus.req_a_1 : bus.req_a_0;
            r_b     <= w_gnt1 ? bus.req_b_1 : bus.req_b_0;
            r_op    <= w_gnt1 ? bus.req_op_1 : bus.req_op_0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_result;
          r_zero   <= w_zero;
          r_rv0    <= ~r_owner;
          r_rv1    <= r_owner;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_rdy) begin
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_prio  <= ~r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_0 = w_gnt0;
  assign bus.req_ready_1 = w_gnt1;
  assign bus.rsp_valid_0 = r_rv0;
  assign bus.rsp_valid_1 = r_rv1;
  assign bus.rsp_result  = r_result;
  assign bus.rsp_zero    = r_zero;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule
